// File: rtl/pc_update_unit.sv
// Program-counter owner for the npc core: fetch handshake, next-PC select, retire counter.
// Optional macro PC_MISALIGN_CHECK_EN adds a sticky misaligned-target trap.
module pc_update_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] pc,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  input  logic            exu_done,
  input  logic [2:0]      pc_src,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  input  logic            branch_taken,
  output logic            redirect,
  output logic [31:0]     retire_cnt,
  output logic            misalign
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC
`ifdef PC_MISALIGN_CHECK_EN
    , S_TRAP
`endif
  } state_t;

  typedef struct packed {
    logic [2:0]      src;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] alu;
    logic            taken;
  } exu_req_t;

  state_t          state;
  exu_req_t        req;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;
  logic            trap_hit;

  assign req = '{src: pc_src, imm: imm, alu: alu_result, taken: branch_taken};

  always_comb begin
    pc_plus4 = pc + XLEN'(4);
    next_pc  = pc_plus4;
    case (req.src)
      3'b001:  next_pc = pc + req.alu;
      3'b010:  next_pc = req.alu & ~XLEN'(1);
      3'b011:  next_pc = req.taken ? pc + req.imm : pc_plus4;
      3'b100:  next_pc = pc + req.imm;
      default: next_pc = pc_plus4;
    endcase
  end

`ifdef PC_MISALIGN_CHECK_EN
  assign trap_hit = (next_pc[1:0] != 2'b00);
`else
  assign trap_hit = 1'b0;
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
      redirect    <= 1'b0;
      retire_cnt  <= 32'd0;
`ifdef PC_MISALIGN_CHECK_EN
      misalign    <= 1'b0;
`endif
    end else begin
      redirect <= 1'b0;
      case (state)
        S_IDLE: begin
          state       <= S_FETCH;
          fetch_valid <= 1'b1;
        end
        S_FETCH: begin
          if (fetch_valid && fetch_ready) begin
            state       <= S_EXEC;
            fetch_valid <= 1'b0;
          end
        end
        S_EXEC: begin
          if (exu_done) begin
            if (trap_hit) begin
`ifdef PC_MISALIGN_CHECK_EN
              // pc keeps the faulting instruction's address
              state    <= S_TRAP;
              misalign <= 1'b1;
`endif
            end else begin
              pc          <= next_pc;
              retire_cnt  <= retire_cnt + 32'd1;
              redirect    <= (next_pc != pc_plus4);
              state       <= S_FETCH;
              fetch_valid <= 1'b1;
            end
          end
        end
`ifdef PC_MISALIGN_CHECK_EN
        S_TRAP: state <= S_TRAP;
`endif
        default: begin
          state       <= S_IDLE;
          fetch_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_update_unit.md
# pc_update_unit

Owns the architectural program counter for the npc core and consumes the 3-bit `PC_src` code produced by the opcode decoder. A small FSM handshakes the current PC to the IFU and waits for the EXU to finish the instruction. It then computes and registers the next PC and counts retired instructions. It sits between the decoder/EXU and the IFU and is the only writer of `pc`.

## Interface
Parameters:
- `XLEN`, 32: PC and datapath width.
- `RESET_PC`, 32'h8000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `pc`  out  XLEN  current PC, registered.
- `fetch_valid`  out  1  PC valid to IFU.
- `fetch_ready`  in  1  IFU accepts `pc`.
- `exu_done`  in  1  one-cycle pulse: current instruction executed; `pc_src`/`imm`/`alu_result`/`branch_taken` valid this cycle.
- `pc_src`  in  3  000 pc+4 (auipc, lui, default), 001 pc+alu_result, 010 alu_result (jalr), 011 branch, 100 jal.
- `imm`  in  XLEN  sign-extended immediate.
- `alu_result`  in  XLEN  ALU output.
- `branch_taken`  in  1  branch condition result; used only when `pc_src`=011.
- `redirect`  out  1  one-cycle pulse: committed next PC ≠ pc+4.
- `retire_cnt`  out  32  retired-instruction counter.
- `misalign`  out  1  sticky misaligned-target flag.

## Operation
- States: IDLE, FETCH, EXEC, TRAP.
- Reset values: `pc`=RESET_PC, `fetch_valid`=0, `redirect`=0, `retire_cnt`=0, `misalign`=0, state=IDLE. Reset overrides every state, including mid-handshake and TRAP.
- IDLE → FETCH unconditionally after one cycle.
- FETCH: `fetch_valid`=1. On `fetch_valid && fetch_ready` → EXEC. `fetch_valid` never drops before the handshake completes. `exu_done` is ignored in FETCH and IDLE.
- EXEC: `fetch_valid`=0. On `exu_done`, next PC is computed combinationally:
  - 000 → pc+4.
  - 001 → pc+alu_result.
  - 010 → alu_result & ~1.
  - 011 → `branch_taken` ? pc+imm : pc+4.
  - 100 → pc+imm.
  - 101–111 → pc+4.
- All additions are modulo 2^XLEN; overflow wraps silently.
- Commit on `exu_done` in EXEC: `pc`←next, `retire_cnt`+1 (wraps 2^32−1→0), `redirect`=1 for exactly the following cycle if next ≠ pc+4, state → FETCH.
- TRAP: see Configuration. `fetch_valid`=0, `pc` frozen, `exu_done` ignored. Only `rst` exits TRAP.

## Timing
- `rst` high at edge N → reset values visible after edge N.
- First cycle with `rst` low is IDLE. `fetch_valid`=1 from the following cycle.
- Handshake at edge E → EXEC from E. `exu_done` at edge D → new `pc`, `redirect`, `retire_cnt` visible after D, and `fetch_valid`=1 in the same cycle.
- Minimum instruction period: 2 cycles (fetch_ready already high, exu_done on the first EXEC cycle).
- Registered outputs only; no combinational path from inputs to outputs.

## Configuration
- Macro `PC_MISALIGN_CHECK_EN`.
- Defined:
  - On commit, if next[1:0] ≠ 00, go to TRAP instead of FETCH.
  - `pc` keeps the faulting instruction's PC.
  - `retire_cnt` does not increment and `redirect` does not pulse.
  - `misalign`=1 and holds until reset.
- Undefined:
  - `misalign` is tied 0 and there is no TRAP state.
  - The computed target is committed as-is; jalr bit 0 is still cleared.

## Test plan
- Reset release, `fetch_ready`=1, `exu_done` each EXEC cycle with `pc_src`=000 ×3 → `pc` = 8000_0000, 8000_0004, 8000_0008, 8000_000C; `retire_cnt`=3; `redirect` never asserted.
- `pc` = 8000_0010, `pc_src`=011, `imm`=FFFF_FFF8, `branch_taken`=1 → `pc`=8000_0008, `redirect` pulses 1 cycle. Repeat with `branch_taken`=0 → 8000_0014, no pulse.
- `pc_src`=010, `alu_result`=8000_0101 → `pc`=8000_0100. `pc_src`=100, `imm`=0000_0020 at `pc`=FFFF_FFF0 → `pc`=0000_0010 (wrap).
- `fetch_ready` held 0 for 5 cycles → `fetch_valid` stays 1 and `pc` stable. A stray `exu_done` during FETCH → no change. Assert `rst` in EXEC → `pc`=RESET_PC, `retire_cnt`=0, IDLE.
- With `PC_MISALIGN_CHECK_EN`: `pc_src`=100, `imm`=2 → `misalign`=1, `fetch_valid` stays 0, `pc` unchanged, `retire_cnt` unchanged; `rst` clears all.
- `retire_cnt` preloaded via 2^32−1 retirements (or force) → next retire gives 0.
